// File: rtl/seg_scan_ctrl_if.sv
// Pin-side bundle for the 7-segment scanner: steering inputs in, registered display drive out.
// Master is the steering/status logic, slave is seg_scan_ctrl.
interface seg_scan_ctrl_if #(
   parameter int DIGITS = 4
);
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic                  en;
   logic [4*DIGITS-1:0]   data;
   logic [DIGITS-1:0]     dp;
   logic [DIGITS-1:0]     digit_en;
   logic [DIGITS-1:0]     an;
   logic [6:0]            seg;
   logic                  dp_n;
   logic [IW-1:0]         digit_idx;

   modport master (
      output en, data, dp, digit_en,
      input  an, seg, dp_n, digit_idx
   );

   modport slave (
      input  en, data, dp, digit_en,
      output an, seg, dp_n, digit_idx
   );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Multiplexed common-anode 7-seg scanner; define SEG_SCAN_LZB_EN for leading-zero blanking.
// All pins registered, one cycle behind cnt/idx; no backpressure, en low freezes the scan and blanks.
module seg_scan_ctrl #(
   parameter int DIGITS = 4,
   parameter int DIV    = 100000,
   parameter int BLANK  = 16
) (
   input  logic          clk,
   input  logic          rst,
   seg_scan_ctrl_if.slave bus
);
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int CW = $clog2(DIV);

   logic [CW-1:0]         cnt;
   logic [IW-1:0]         idx;
   logic [4*DIGITS-1:0]   data_snap;
   logic [DIGITS-1:0]     dp_snap;
   logic [DIGITS-1:0]     den_snap;
   logic [DIGITS-1:0]     sup;

   logic [DIGITS-1:0]     an_q;
   logic [6:0]            seg_q;
   logic                  dp_n_q;
   logic [IW-1:0]         idx_q;

   logic [3:0]            nib_cur;
   logic                  dp_cur;
   logic                  den_cur;
   logic                  sup_cur;
   logic                  visible;
   logic [DIGITS-1:0]     an_next;
   logic                  slot_end;
   logic                  frame_end;

   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 7'b1000000;
         4'h1: hex7 = 7'b1111001;
         4'h2: hex7 = 7'b0100100;
         4'h3: hex7 = 7'b0110000;
         4'h4: hex7 = 7'b0011001;
         4'h5: hex7 = 7'b0010010;
         4'h6: hex7 = 7'b0000010;
         4'h7: hex7 = 7'b1111000;
         4'h8: hex7 = 7'b0000000;
         4'h9: hex7 = 7'b0010000;
         4'hA: hex7 = 7'b0001000;
         4'hB: hex7 = 7'b0000011;
         4'hC: hex7 = 7'b1000110;
         4'hD: hex7 = 7'b0100001;
         4'hE: hex7 = 7'b0000110;
         default: hex7 = 7'b0001110;
      endcase
   endfunction

`ifdef SEG_SCAN_LZB_EN
   // Walk down from the top digit; disabled digits do not break a run of leading zeros.
   always_comb begin
      logic run_zero;
      sup      = '0;
      run_zero = 1'b1;
      for (int k = DIGITS - 1; k >= 1; k--) begin
         if (den_snap[k]) begin
            if (data_snap[4*k +: 4] == 4'h0) begin
               sup[k] = run_zero && !dp_snap[k];
            end else begin
               run_zero = 1'b0;
            end
         end
      end
   end
`else
   assign sup = '0;
`endif

   always_comb begin
      nib_cur = 4'h0;
      dp_cur  = 1'b0;
      den_cur = 1'b0;
      sup_cur = 1'b0;
      for (int k = 0; k < DIGITS; k++) begin
         if (idx == IW'(k)) begin
            nib_cur = data_snap[4*k +: 4];
            dp_cur  = dp_snap[k];
            den_cur = den_snap[k];
            sup_cur = sup[k];
         end
      end
      visible = bus.en && den_cur && !sup_cur && (cnt >= CW'(BLANK));
      an_next = '1;
      for (int k = 0; k < DIGITS; k++) begin
         if (visible && (idx == IW'(k))) begin
            an_next[k] = 1'b0;
         end
      end
   end

   assign slot_end  = (cnt == CW'(DIV - 1));
   assign frame_end = slot_end && (idx == IW'(DIGITS - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         idx       <= '0;
         data_snap <= bus.data;
         dp_snap   <= bus.dp;
         den_snap  <= bus.digit_en;
         an_q      <= '1;
         seg_q     <= 7'h7F;
         dp_n_q    <= 1'b1;
         idx_q     <= '0;
      end else begin
         an_q   <= an_next;
         seg_q  <= visible ? hex7(nib_cur) : 7'h7F;
         dp_n_q <= visible ? ~dp_cur : 1'b1;
         idx_q  <= idx;
         if (bus.en) begin
            if (slot_end) begin
               cnt <= '0;
               if (frame_end) begin
                  // Frame start: take a fresh snapshot so a frame never mixes old and new data.
                  idx       <= '0;
                  data_snap <= bus.data;
                  dp_snap   <= bus.dp;
                  den_snap  <= bus.digit_en;
               end else begin
                  idx <= idx + 1'b1;
               end
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

   assign bus.an        = an_q;
   assign bus.seg       = seg_q;
   assign bus.dp_n      = dp_n_q;
   assign bus.digit_idx = idx_q;
endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Parametrised multiplexed 7-segment display scanner for the Basys3 board and any other common-anode, active-low display. It drives DIGITS anodes in a rotating scan with a programmable per-digit dwell time and an inter-digit blanking gap. It decodes one hex nibble per digit to segments and applies per-digit enable and decimal-point masks. It sits between the steering/status logic and the board pins, taking a packed nibble bus and producing registered `an`, `seg` and `dp_n`.

## Interface
- DIGITS, 4: number of digits scanned, legal 1..8.
- DIV, 100000: clk cycles per digit slot, legal ≥ 2.
- BLANK, 16: cycles at start of each slot with all anodes off, legal 0..DIV-1.
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  scan enable; low freezes the scan and blanks the display.
- data  in  4*DIGITS  hex nibble per digit; digit k = data[4k+3:4k].
- dp  in  DIGITS  decimal point request per digit, active high.
- digit_en  in  DIGITS  per-digit display enable, active high.
- an  out  DIGITS  anode drive, active low.
- seg  out  7  segments {g,f,e,d,c,b,a}, active low.
- dp_n  out  1  decimal point, active low.
- digit_idx  out  $clog2(DIGITS) (min 1)  index of the current slot.

## Operation
- Internal state:
  - cnt, 0..DIV-1: slot cycle counter.
  - idx, 0..DIGITS-1: current digit.
  - Frame snapshot of data, dp and digit_en.
- While en is high, cnt increments every cycle. At cnt == DIV-1, cnt returns to 0 and idx advances. idx wraps from DIGITS-1 to 0. With DIGITS=1, idx stays 0.
- Snapshot loading:
  - The snapshot loads from the inputs on every rst cycle.
  - It also loads on the cycle idx wraps to 0, which is a frame start.
  - Input changes mid-frame have no effect until the next frame. This prevents tearing.
- Digit visibility: a digit is visible when `digit_en_snap[idx]` is 1, cnt ≥ BLANK, and en is 1.
- Outputs when the digit is visible:
  - an = ~(1<<idx).
  - seg = hex decode of the snapshot nibble, with standard 0-F glyphs (for example, 0 → 7'b1000000, 8 → 7'b0000000, F → 7'b0001110).
  - dp_n = ~dp_snap[idx].
- Outputs when the digit is not visible: an all ones, seg 7'h7F, dp_n 1.
- en low behaviour:
  - cnt and idx hold their values.
  - Outputs blank one cycle later.
  - When en returns high, counting resumes from the held cnt and idx.
- Reset values: cnt 0, idx 0, an all ones, seg 7'h7F, dp_n 1, digit_idx 0. Reset mid-slot aborts the slot immediately.

## Timing
- an, seg, dp_n and digit_idx are all registered and lag the internal cnt/idx by exactly one cycle. All of them change on the same edge, so there are no glitches on the pins.
- Slot length: exactly DIV cycles. Frame length: DIGITS*DIV cycles.
- Within each slot:
  - Anodes are off for the first BLANK output cycles.
  - The addressed anode is low for the remaining DIV-BLANK cycles.
- After rst deasserts at edge 0, the first anode-low cycle is output cycle BLANK+1.
- Data latency: an input change appears on seg at the first visible cycle of the next frame start at the earliest.
- rst has priority over en.

## Configuration
- SEG_SCAN_LZB_EN: leading-zero blanking.
  - When defined: an enabled digit k > 0 is forced invisible if its snapshot nibble is 0 and every enabled digit above it also has a 0 nibble. Digit 0 is never suppressed. A digit with its dp_snap bit set is never suppressed. The decision is computed from the frame snapshot.
  - When undefined: all enabled digits display, including leading zeros.

## Test plan
- DIGITS=4, DIV=8, BLANK=2, data=16'h1234, dp=0, digit_en=4'hF. After reset, check the following:
  - The an sequence is 1111,1111,1110×6, 1111×2, 1101×6, … repeating with a 32-cycle period.
  - seg shows 4 (7'b0011001) under an=1110 and 1 (7'b1111001) under an=0111.
- Change data to 16'hABCD at mid-frame → segments unchanged until idx next wraps to 0, then digit 0 shows D (7'b0100001).
- Drive en low for 5 cycles in mid-slot → an=all ones from the next cycle. cnt and idx are frozen. After en rises, the slot completes its remaining cycles and total slot time is unchanged.
- digit_en=4'b0101, dp=4'b0100 → an never asserts bits 1 or 3. dp_n=0 only while an=1011.
- rst asserted during a visible slot of digit 2 → next cycle an=all ones, seg=7'h7F, dp_n=1. digit_idx=0 one cycle after rst.
- With SEG_SCAN_LZB_EN, data=16'h0050 → digits 3 and 2 are blanked, digits 1 and 0 show 5 and 0. Without the macro, all four digits show.
